// File: rtl/vmem_pkg.sv
// Shared types for the vector data-memory responder: FSM state encoding and
// the default lane-vector shape used by the datapath.
package vmem_pkg;

    localparam int unsigned LANES  = 6;
    localparam int unsigned LANE_W = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BUSY  = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } vmem_state_t;

    typedef logic [LANES-1:0][LANE_W-1:0] vec_t;

endpackage

// File: rtl/byte_ram.sv
// Single-port, N-bit wide synchronous RAM with 1-cycle read latency.
module byte_ram #(
    parameter int unsigned N         = 8,
    parameter int unsigned AW        = 16,
    parameter string       INIT_FILE = ""
) (
    input  logic          clk,
    input  logic          en,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [N-1:0]  wdata,
    output logic [N-1:0]  rdata
);

    logic [N-1:0] mem [0:(1<<AW)-1];

    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                mem[addr] <= wdata;
            end else begin
                rdata <= mem[addr];
            end
        end
    end

endmodule

// File: rtl/vec_data_mem.sv
// M-stage vector memory responder: serializes an R-lane load/store onto a
// byte-wide single-port RAM, one lane per cycle, stalling the pipeline.
module vec_data_mem
    import vmem_pkg::*;
#(
    parameter int unsigned N         = 8,
    parameter int unsigned R         = 6,
    parameter int unsigned I         = 32,
    parameter int unsigned AW        = 16,
    parameter string       INIT_FILE = ""
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                MemReadM,
    input  logic                MemWriteM,
    input  logic [I-1:0]        AddressM,
    input  logic [R-1:0][N-1:0] WriteDataM,
    output logic [R-1:0][N-1:0] ReadData,
    output logic                StallM
);

    localparam int unsigned   CW   = (R > 1) ? $clog2(R) : 1;
    localparam logic [CW-1:0] LAST = CW'(R - 1);

    vmem_state_t         state_q, state_d;
    logic [CW-1:0]       cnt_q;
    logic [AW-1:0]       base_q;
    logic [R-1:0][N-1:0] wdata_q;
    logic [R-1:0][N-1:0] gather_q;
    logic [R-1:0][N-1:0] read_data_q;
    logic                store_q;
    logic                req;

    logic                ram_en;
    logic                ram_we;
    logic [AW-1:0]       ram_addr;
    logic [N-1:0]        ram_wdata;
    logic [N-1:0]        ram_rdata;

    logic                unused_addr_hi;
    assign unused_addr_hi = ^AddressM[I-1:AW];

    assign req = MemReadM | MemWriteM;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (req) state_d = BUSY;
            BUSY:    if (cnt_q == LAST) state_d = store_q ? DONE : DRAIN;
            DRAIN:   state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Address arithmetic is AW bits wide, so base+cnt wraps modulo 2^AW.
    assign ram_en    = (state_q == BUSY);
    assign ram_we    = ram_en & store_q;
    assign ram_addr  = base_q + AW'(cnt_q);
    assign ram_wdata = wdata_q[cnt_q];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            base_q      <= '0;
            wdata_q     <= '0;
            store_q     <= 1'b0;
            gather_q    <= '0;
            read_data_q <= '0;
        end else begin
            state_q <= state_d;
            unique case (state_q)
                IDLE: begin
                    if (req) begin
                        base_q  <= AddressM[AW-1:0];
                        wdata_q <= WriteDataM;
                        store_q <= MemWriteM;
                        cnt_q   <= '0;
                    end
                end
                BUSY: begin
                    cnt_q <= cnt_q + 1'b1;
                    // Read data lags the issued address by one cycle.
                    if (!store_q && cnt_q != '0) begin
                        gather_q[cnt_q - 1'b1] <= ram_rdata;
                    end
                end
                DRAIN: begin
                    read_data_q      <= gather_q;
                    read_data_q[R-1] <= ram_rdata;
                end
                default: ;
            endcase
        end
    end

    assign ReadData = read_data_q;
    assign StallM   = ~reset & (((state_q == IDLE) & req) | (state_q == BUSY) |
                                (state_q == DRAIN));

    byte_ram #(
        .N         (N),
        .AW        (AW),
        .INIT_FILE (INIT_FILE)
    ) u_ram (
        .clk   (clk),
        .en    (ram_en),
        .we    (ram_we),
        .addr  (ram_addr),
        .wdata (ram_wdata),
        .rdata (ram_rdata)
    );

endmodule
